// File: rtl/sys_array_pkg.sv
// Shared types and constants for the systolic-array input skew feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sys_array_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ARRAY_H    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_t;

  // LSB position of lane `lane` inside a packed vector of `width`-bit elements.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sys_array_delay_line.sv
// Fixed-depth register chain carrying data, valid and a tag bit-field.
// Latency: DEPTH cycles from input to output.
// Backpressure: none; advances on every clock edge.
module sys_array_delay_line
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 1,
  parameter int TAG_W      = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [TAG_W-1:0]      tag_o
);

  logic [DATA_WIDTH-1:0] dat_q [DEPTH];
  logic                  vld_q [DEPTH];
  logic [TAG_W-1:0]      tag_q [DEPTH];

  // Shift every stage one step per edge; reset clears the whole chain at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        dat_q[s] <= '0;
        vld_q[s] <= 1'b0;
        tag_q[s] <= '0;
      end
    end else begin
      dat_q[0] <= dat_i;
      vld_q[0] <= vld_i;
      tag_q[0] <= tag_i;
      for (int s = 1; s < DEPTH; s++) begin
        dat_q[s] <= dat_q[s-1];
        vld_q[s] <= vld_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign dat_o = dat_q[DEPTH-1];
  assign vld_o = vld_q[DEPTH-1];
  assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/sys_array_input_skew.sv
// Diagonal-skew feeder: lane i of each accepted vector emerges i+1 cycles later.
// Latency: lane 0 one cycle, lane ARRAY_H-1 ARRAY_H cycles.
// Backpressure: in_ready drops for ARRAY_H-1 cycles after a tile's last vector.
module sys_array_input_skew
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_H    = DEF_ARRAY_H
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ARRAY_H*DATA_WIDTH-1:0] in_data,
  input  logic                          in_last,
  output logic [ARRAY_H*DATA_WIDTH-1:0] out_data,
  output logic [ARRAY_H-1:0]            out_valid,
  output logic                          out_last,
  output logic                          busy
);

  // Counter only needs to hold ARRAY_H-2 (the largest load value).
  localparam int CNT_W = (ARRAY_H > 2) ? $clog2(ARRAY_H - 1) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((ARRAY_H >= 2) ? ARRAY_H - 2 : 0);

  skew_state_t      state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             hs;
  logic [ARRAY_H-1:0] lane_tag;

  // Ready is a pure function of state so there is no path from in_valid.
  assign in_ready = (state_q != DRAIN);
  assign hs       = in_valid & in_ready;
  assign busy     = (state_q != IDLE);

  // State register and drain counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state: the last vector opens a drain window covering the full skew.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE, STREAM: begin
        if (hs) begin
          if (in_last) begin
            if (ARRAY_H > 1) begin
              state_d     = DRAIN;
              drain_cnt_d = DRAIN_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

  // One chain per lane; empty slots enter as zero data with valid low.
  for (genvar i = 0; i < ARRAY_H; i++) begin : g_lane
    localparam int  LSB     = lane_lsb(i, DATA_WIDTH);
    localparam bit  IS_LAST = (i == ARRAY_H - 1);

    logic [DATA_WIDTH-1:0] lane_dat;
    logic                  lane_tag_in;

    assign lane_dat    = hs ? in_data[LSB +: DATA_WIDTH] : '0;
    assign lane_tag_in = IS_LAST ? (hs & in_last) : 1'b0;

    sys_array_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (i + 1),
      .TAG_W      (1)
    ) u_delay (
      .clock   (clock),
      .reset_n (reset_n),
      .vld_i   (hs),
      .dat_i   (lane_dat),
      .tag_i   (lane_tag_in),
      .vld_o   (out_valid[i]),
      .dat_o   (out_data[LSB +: DATA_WIDTH]),
      .tag_o   (lane_tag[i])
    );
  end

  // Only the last lane ever carries a set tag; the others are constant zero.
  assign out_last = |lane_tag;

endmodule

// File: tb/tb_sys_array_input_skew.sv
module tb_sys_array_input_skew;

  localparam int DW = 8;
  localparam int AH = 4;

  logic           clock;
  logic           clk_en;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [AH*DW-1:0] in_data;
  logic           in_last;
  logic [AH*DW-1:0] out_data;
  logic [AH-1:0]  out_valid;
  logic           out_last;
  logic           busy;

  int n_checks;
  int n_fail;

  sys_array_input_skew #(
    .DATA_WIDTH (DW),
    .ARRAY_H    (AH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 if (clk_en) clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clk_en   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want %h", out_data, 32'h0);
    end
    n_checks++;
    if ({out_valid, out_last, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid/last/busy got %b want %b", {out_valid, out_last, busy}, 6'b0);
    end
    clk_en = 1'b1;
    step();
    step();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: ready/busy got %b want %b", {in_ready, busy}, 2'b10);
    end
  endtask

  // flags = {out_valid[3:0], out_last, in_ready, busy}
  task automatic test_single();
    logic        iv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] id [5] = '{32'h04030201, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA};
    logic        il [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ed [5] = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000, 32'h00000000};
    logic [6:0]  ef [5] = '{7'b0001001, 7'b0010001, 7'b0100001, 7'b1000110, 7'b0000010};
    for (int c = 0; c < 5; c++) begin
      in_valid = iv[c]; in_data = id[c]; in_last = il[c];
      step();
      n_checks++;
      if (out_data !== ed[c]) begin
        n_fail++;
        $display("FAIL single_data e%0d: got %h want %h", c, out_data, ed[c]);
      end
      n_checks++;
      if ({out_valid, out_last, in_ready, busy} !== ef[c]) begin
        n_fail++;
        $display("FAIL single_flags e%0d: got %b want %b", c, {out_valid, out_last, in_ready, busy}, ef[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        iv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] id [6] = '{32'h80808080, 32'h7F7F7F7F, 32'h55555555, 32'h0, 32'h0, 32'h0};
    logic        il [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ed [6] = '{32'h00000080, 32'h0000807F, 32'h00807F55,
                            32'h807F5500, 32'h7F550000, 32'h55000000};
    logic [6:0]  ef [6] = '{7'b0001011, 7'b0011011, 7'b0111001,
                            7'b1110001, 7'b1100001, 7'b1000110};
    for (int c = 0; c < 6; c++) begin
      in_valid = iv[c]; in_data = id[c]; in_last = il[c];
      step();
      n_checks++;
      if (out_data !== ed[c]) begin
        n_fail++;
        $display("FAIL b2b_data e%0d: got %h want %h", c, out_data, ed[c]);
      end
      n_checks++;
      if ({out_valid, out_last, in_ready, busy} !== ef[c]) begin
        n_fail++;
        $display("FAIL b2b_flags e%0d: got %b want %b", c, {out_valid, out_last, in_ready, busy}, ef[c]);
      end
    end
  endtask

  task automatic test_bubble();
    logic        iv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] id [6] = '{32'h14131211, 32'hFFFFFFFF, 32'h24232221,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        il [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ed [6] = '{32'h00000011, 32'h00001200, 32'h00130021,
                            32'h14002200, 32'h00230000, 32'h24000000};
    logic [6:0]  ef [6] = '{7'b0001011, 7'b0010011, 7'b0101001,
                            7'b1010001, 7'b0100001, 7'b1000110};
    for (int c = 0; c < 6; c++) begin
      in_valid = iv[c]; in_data = id[c]; in_last = il[c];
      step();
      n_checks++;
      if (out_data !== ed[c]) begin
        n_fail++;
        $display("FAIL bubble_data e%0d: got %h want %h", c, out_data, ed[c]);
      end
      n_checks++;
      if ({out_valid, out_last, in_ready, busy} !== ef[c]) begin
        n_fail++;
        $display("FAIL bubble_flags e%0d: got %b want %b", c, {out_valid, out_last, in_ready, busy}, ef[c]);
      end
    end
  endtask

  // Leaves the block in STREAM with data in flight for the reset test.
  task automatic test_drain_stall();
    logic        iv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] id [6] = '{32'h34333231, 32'h7F7F7F7F, 32'h7F7F7F7F,
                            32'h7F7F7F7F, 32'h7F7F7F7F, 32'h44434241};
    logic        il [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ed [6] = '{32'h00000031, 32'h00003200, 32'h00330000,
                            32'h34000000, 32'h0000007F, 32'h00007F41};
    logic [6:0]  ef [6] = '{7'b0001001, 7'b0010001, 7'b0100001,
                            7'b1000110, 7'b0001011, 7'b0011011};
    for (int c = 0; c < 6; c++) begin
      in_valid = iv[c]; in_data = id[c]; in_last = il[c];
      step();
      n_checks++;
      if (out_data !== ed[c]) begin
        n_fail++;
        $display("FAIL stall_data e%0d: got %h want %h", c, out_data, ed[c]);
      end
      n_checks++;
      if ({out_valid, out_last, in_ready, busy} !== ef[c]) begin
        n_fail++;
        $display("FAIL stall_flags e%0d: got %b want %b", c, {out_valid, out_last, in_ready, busy}, ef[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b0;
    in_data  = 32'hFFFFFFFF;
    in_last  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL areset_data: got %h want %h", out_data, 32'h0);
    end
    n_checks++;
    if ({out_valid, out_last, in_ready, busy} !== 7'b0000010) begin
      n_fail++;
      $display("FAIL areset_flags: got %b want %b", {out_valid, out_last, in_ready, busy}, 7'b0000010);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (out_data !== '0) begin
        n_fail++;
        $display("FAIL post_reset_data e%0d: got %h want %h", c, out_data, 32'h0);
      end
      n_checks++;
      if ({out_valid, out_last, in_ready, busy} !== 7'b0000010) begin
        n_fail++;
        $display("FAIL post_reset_flags e%0d: got %b want %b", c, {out_valid, out_last, in_ready, busy}, 7'b0000010);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_drain_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_array_input_skew.md
Name: sys_array_input_skew

Overview:
Feeder stage directly upstream of the systolic cell grid. Accepts one activation vector per cycle, one element per array row, through a valid/ready handshake. Drives each row's input_data with a diagonal skew: row i is delayed by i cycles, so partial sums meet matching operands as they propagate. After the last vector of a tile, the block inserts zero bubbles until the skew pipeline has drained.

Parameters:
DATA_WIDTH, 8, signed element width; matches the cell input_data width.
ARRAY_H, 4, number of array rows (lanes), minimum 1.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream vector valid.
in_ready  output  1  block can accept a vector this cycle.
in_data  input  ARRAY_H*DATA_WIDTH  signed vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
in_last  input  1  qualifies the final vector of a tile; sampled only on handshake.
out_data  output  ARRAY_H*DATA_WIDTH  skewed lanes to the cell rows; lane i feeds row i input_data.
out_valid  output  ARRAY_H  per-lane valid for the current out_data lane.
out_last  output  1  lane ARRAY_H-1 currently carries the last vector's element.
busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0): all lane registers, out_data, out_valid, out_last, drain counter and state clear to 0/IDLE immediately, with no clock edge required. in_ready is 1 in the first cycle after release. A reset mid-stream discards all in-flight data.
- Handshake: a vector is accepted at a rising edge where in_valid and in_ready are both 1. in_ready depends only on state (no combinational path from in_valid):
  - IDLE and STREAM: in_ready=1.
  - DRAIN: in_ready=0.
- Pipeline advances on every clock edge regardless of handshake. There is no downstream backpressure, because the cell array never stalls.
- Lane i has a register chain of depth i+1. An element accepted at edge k appears on out_data lane i after edge k+i and stays for exactly one cycle.
  - Lane 0 latency: 1 cycle.
  - Lane ARRAY_H-1 latency: ARRAY_H cycles.
- Empty slot: on any edge without a handshake, a bubble enters the chain: data=0, valid=0. Bubbles emerge at the same skew. Zero data is mandatory, so cells accumulate nothing.
- Data passes bit-exact. There is no arithmetic, sign change or width change.
- out_last: a tag bit travels with lane ARRAY_H-1's chain only. It asserts for one cycle when the in_last vector's lane ARRAY_H-1 element is on out_data.
- State machine:
  - IDLE: on a handshake with in_last=0, go to STREAM. On a handshake with in_last=1, go to DRAIN, or stay in IDLE if ARRAY_H=1.
  - STREAM: a handshake with in_last=1 goes to DRAIN (or IDLE if ARRAY_H=1) and loads drain_cnt=ARRAY_H-2. Otherwise stay in STREAM.
  - DRAIN: decrement drain_cnt each edge. At drain_cnt=0, go to IDLE. DRAIN therefore lasts exactly ARRAY_H-1 cycles.
- End-of-tile timing: when IDLE is re-entered, out_last for that tile is on the outputs in the same cycle that in_ready returns to 1. A new vector accepted in that cycle appears on lane 0 on the next cycle, with no overlap with the prior tile's data.
- in_valid=1 during DRAIN is ignored. No data is captured, and upstream must hold its vector.
- busy=1 in STREAM and DRAIN. It does not reflect bubbles still in flight in IDLE, which cannot occur, since DRAIN covers the full skew.

Decomposition:
- Shared package sys_array_pkg holds:
  - default DATA_WIDTH and ARRAY_H constants;
  - the state enum skew_state_t {IDLE, STREAM, DRAIN};
  - the lane-slice helper function for the packed vector.
- Sub-module sys_array_delay_line (parameters DATA_WIDTH, DEPTH, TAG_W): a register chain carrying data, valid and optional tag, with asynchronous active-low reset. It is instantiated once per lane with DEPTH=i+1.
- The FSM and drain counter live in the top module.

Test Plan:
- Reset: hold reset_n=0, pulse no clocks -> out_data=0, out_valid=0, out_last=0, busy=0. After release, in_ready=1.
- Single vector, ARRAY_H=4: lanes {0x01,0x02,0x03,0x04} with in_last=1 accepted at edge 0 -> lane0=0x01 valid after edge 0, lane1=0x02 after edge 1, lane2=0x03 after edge 2, lane3=0x04 with out_last=1 after edge 3. in_ready=0 for cycles after edges 0..2 and 1 after edge 3.
- Back-to-back: 3 vectors with lane values -128/127/0x55 on consecutive edges, last on the third -> each lane shows 3 consecutive valid elements, bit-exact and correctly skewed. out_last is only on the third element of lane 3.
- Bubble: in_valid=0 for one cycle between two vectors -> every lane shows a one-cycle gap with data=0 and valid=0 at that lane's skew.
- Drain stall: in_valid held 1 with a new vector (0x7F in every lane) during DRAIN -> not accepted. It is accepted on the first cycle in_ready=1, and lane0=0x7F appears one cycle later.
- Async reset mid-stream: assert reset_n=0 between clock edges while valid data is in flight -> all outputs drop to 0 immediately. After release, state is IDLE and no stale data emerges.
